// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encodings, register constants, defaults.
package pipe_defs;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01
    } state_t;

    localparam logic [4:0]  REG_X0           = 5'd0;
    localparam int unsigned LOAD_LATENCY_DEF = 1;
    // Remaining-stall counter width; covers LOAD_LATENCY up to 15.
    localparam int unsigned REM_W            = 4;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // Count register: clear first, then increment unless already all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, EX redirect flushes, perf counters.
module hazard_ctrl
    import pipe_defs::*;
#(
    parameter int unsigned LOAD_LATENCY = LOAD_LATENCY_DEF,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             cnt_clear,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             stall_active,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    state_t           state_q, state_d;
    logic [REM_W-1:0] rem_q, rem_d;
    logic             hz;
    logic             stall_inc;

    assign hz = ex_mem_read && (ex_rd != REG_X0) &&
                ((id_use_rs1 && (ex_rd == id_rs1)) ||
                 (id_use_rs2 && (ex_rd == id_rs2)));

    assign state = state_q;

    // State, remaining-stall count and registered stall indicator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            rem_q        <= '0;
            stall_active <= 1'b0;
        end else begin
            state_q      <= state_d;
            rem_q        <= rem_d;
            stall_active <= (state_d == ST_STALL);
        end
    end

    // Next state and enables; redirect overrides any stall, reset forces a flush.
    always_comb begin
        state_d     = ST_RUN;
        rem_d       = '0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        id_ex_write = 1'b1;
        if_id_flush = 1'b0;
        stall_inc   = 1'b0;

        if (ex_redirect) begin
            id_ex_write = 1'b0;
            if_id_flush = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (hz) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_write = 1'b0;
                        stall_inc   = 1'b1;
                        if (LOAD_LATENCY > 1) begin
                            state_d = ST_STALL;
                            rem_d   = REM_W'(LOAD_LATENCY - 1);
                        end
                    end
                end
                ST_STALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_write = 1'b0;
                    stall_inc   = 1'b1;
                    if (rem_q > REM_W'(1)) begin
                        state_d = ST_STALL;
                        rem_d   = rem_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end

        if (!rst_n) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .clr   (cnt_clear),
        .cnt   (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ex_redirect),
        .clr   (cnt_clear),
        .cnt   (flush_events)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: three hazard_ctrl configurations share one stimulus stream.
// Instance 0: LOAD_LATENCY=1, CNT_W=32; 1: LOAD_LATENCY=3, CNT_W=32; 2: LOAD_LATENCY=1, CNT_W=4.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, cnt_clear;

    logic       pc_write [3];
    logic       if_id_write [3];
    logic       if_id_flush [3];
    logic       id_ex_write [3];
    logic       stall_active [3];
    logic [1:0] state [3];
    logic [31:0] sc0, sc1, fe0, fe1;
    logic [3:0]  sc2, fe2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .cnt_clear(cnt_clear),
        .pc_write(pc_write[0]), .if_id_write(if_id_write[0]), .if_id_flush(if_id_flush[0]),
        .id_ex_write(id_ex_write[0]), .stall_active(stall_active[0]), .state(state[0]),
        .stall_cycles(sc0), .flush_events(fe0));

    hazard_ctrl #(.LOAD_LATENCY(3), .CNT_W(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .cnt_clear(cnt_clear),
        .pc_write(pc_write[1]), .if_id_write(if_id_write[1]), .if_id_flush(if_id_flush[1]),
        .id_ex_write(id_ex_write[1]), .stall_active(stall_active[1]), .state(state[1]),
        .stall_cycles(sc1), .flush_events(fe1));

    hazard_ctrl #(.LOAD_LATENCY(1), .CNT_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_mem_read(ex_mem_read),
        .ex_rd(ex_rd), .ex_redirect(ex_redirect), .cnt_clear(cnt_clear),
        .pc_write(pc_write[2]), .if_id_write(if_id_write[2]), .if_id_flush(if_id_flush[2]),
        .id_ex_write(id_ex_write[2]), .stall_active(stall_active[2]), .state(state[2]),
        .stall_cycles(sc2), .flush_events(fe2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Enables of one instance packed as {pc_write, if_id_write, id_ex_write, if_id_flush}.
    function automatic logic [31:0] en(input int i);
        return {28'd0, pc_write[i], if_id_write[i], id_ex_write[i], if_id_flush[i]};
    endfunction

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; ex_redirect = 1'b0; cnt_clear = 1'b0;
    endtask

    task automatic hazard();
        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    endtask

    // Inputs change on the falling edge; combinational outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(); idle(); rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #1;
        // Reset state and forced outputs
        chk("rst_en0", en(0), 32'b0001);
        chk("rst_en1", en(1), 32'b0001);
        chk("rst_state1", {30'd0, state[1]}, 32'd0);
        chk("rst_sa1", {31'd0, stall_active[1]}, 32'd0);
        chk("rst_sc0", sc0, 32'd0);
        chk("rst_fe2", {28'd0, fe2}, 32'd0);
        step(); rst_n = 1'b1; #1;
        chk("run_en0", en(0), 32'b1110);

        // Basic load-use, LOAD_LATENCY=1
        step(); hazard(); #1;
        chk("lu_en0", en(0), 32'b0000);
        step(); idle(); #1;
        chk("lu_after_en0", en(0), 32'b1110);
        chk("lu_sc0", sc0, 32'd1);
        chk("lu_state0", {30'd0, state[0]}, 32'd0);
        chk("lu_sa0", {31'd0, stall_active[0]}, 32'd0);

        // No false hazards
        do_reset();
        step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; #1;
        chk("nf_x0_en0", en(0), 32'b1110);
        step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b0; #1;
        chk("nf_nouse_en0", en(0), 32'b1110);
        step(); idle(); ex_mem_read = 1'b0; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1; #1;
        chk("nf_noload_en1", en(1), 32'b1110);
        step(); idle(); ex_mem_read = 1'b1; ex_rd = 5'd12; id_rs2 = 5'd12; id_use_rs2 = 1'b1; #1;
        chk("rs2_hz_en0", en(0), 32'b0000);
        step(); idle(); #1;
        chk("nf_sc0", sc0, 32'd1);

        // Long latency, LOAD_LATENCY=3
        do_reset();
        step(); hazard(); #1;
        chk("ll_c1_en1", en(1), 32'b0000);
        chk("ll_c1_state1", {30'd0, state[1]}, 32'd0);
        step(); idle(); #1;
        chk("ll_c2_en1", en(1), 32'b0000);
        chk("ll_c2_state1", {30'd0, state[1]}, 32'd1);
        chk("ll_c2_sa1", {31'd0, stall_active[1]}, 32'd1);
        step(); #1;
        chk("ll_c3_en1", en(1), 32'b0000);
        chk("ll_c3_state1", {30'd0, state[1]}, 32'd1);
        chk("ll_c3_sa1", {31'd0, stall_active[1]}, 32'd1);
        step(); #1;
        chk("ll_c4_en1", en(1), 32'b1110);
        chk("ll_c4_state1", {30'd0, state[1]}, 32'd0);
        chk("ll_c4_sa1", {31'd0, stall_active[1]}, 32'd0);
        chk("ll_sc1", sc1, 32'd3);

        // Redirect alone
        do_reset();
        step(); idle(); ex_redirect = 1'b1; #1;
        chk("rd_en0", en(0), 32'b1101);
        step(); idle(); #1;
        chk("rd_after_en0", en(0), 32'b1110);
        chk("rd_fe0", fe0, 32'd1);

        // Redirect together with hazard: redirect wins
        step(); hazard(); ex_redirect = 1'b1; #1;
        chk("rdhz_en0", en(0), 32'b1101);
        chk("rdhz_en1", en(1), 32'b1101);
        step(); idle(); #1;
        chk("rdhz_state1", {30'd0, state[1]}, 32'd0);
        chk("rdhz_sc1", sc1, 32'd0);
        chk("rdhz_fe1", fe1, 32'd2);

        // Redirect on first STALL-state cycle aborts the stall
        do_reset();
        step(); hazard(); #1;
        step(); idle(); ex_redirect = 1'b1; #1;
        chk("ab1_en1", en(1), 32'b1101);
        step(); idle(); #1;
        chk("ab1_state1", {30'd0, state[1]}, 32'd0);
        chk("ab1_en1_run", en(1), 32'b1110);
        chk("ab1_sc1", sc1, 32'd1);

        // Redirect on the second STALL-state cycle
        do_reset();
        step(); hazard(); #1;
        step(); idle(); #1;
        step(); idle(); ex_redirect = 1'b1; #1;
        chk("ab2_state1", {30'd0, state[1]}, 32'd1);
        chk("ab2_en1", en(1), 32'b1101);
        step(); idle(); #1;
        chk("ab2_state_after1", {30'd0, state[1]}, 32'd0);
        chk("ab2_sc1", sc1, 32'd2);

        // Reset in the middle of a stall
        do_reset();
        step(); hazard(); #1;
        step(); idle(); #1;
        chk("rms_pre_state1", {30'd0, state[1]}, 32'd1);
        rst_n = 1'b0; #1;
        chk("rms_state1", {30'd0, state[1]}, 32'd0);
        chk("rms_en1", en(1), 32'b0001);
        chk("rms_sc1", sc1, 32'd0);
        chk("rms_sa1", {31'd0, stall_active[1]}, 32'd0);
        step(); rst_n = 1'b1; #1;
        chk("rms_rel_en1", en(1), 32'b1110);
        step(); #1;
        chk("rms_rel_state1", {30'd0, state[1]}, 32'd0);

        // Saturation with CNT_W=4
        do_reset();
        for (int unsigned i = 0; i < 20; i++) begin
            step(); hazard(); ex_redirect = 1'b1;
            if (i >= 3) ex_redirect = 1'b0;
        end
        step(); idle(); #1;
        chk("sat_sc2", {28'd0, sc2}, 32'd15);
        chk("sat_sc0", sc0, 32'd17);
        chk("sat_fe2", {28'd0, fe2}, 32'd3);

        // Clear beats simultaneous increment
        step(); hazard(); ex_redirect = 1'b0; cnt_clear = 1'b1; #1;
        step(); idle(); #1;
        chk("clr_sc2", {28'd0, sc2}, 32'd0);
        chk("clr_sc0", sc0, 32'd0);
        chk("clr_fe0", fe0, 32'd0);
        step(); hazard(); #1;
        step(); idle(); #1;
        chk("post_clr_sc0", sc0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control block that produces the write and flush enables for PC, IF/ID and ID/EX.
- It is the driving end of the ID/EX interface: it decides each cycle whether ID/EX loads the decoded instruction (id_ex_write=1) or captures a bubble (id_ex_write=0, which zeroes ID/EX).
- Handles load-use stalls of configurable length and EX-stage redirect flushes (taken branch or jal).
- Keeps two saturating performance counters.

Parameters:
- LOAD_LATENCY, default 1: bubble cycles inserted per load-use hazard; legal range 1..15.
- CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  rd of the instruction in EX
- ex_redirect  in  1  EX resolved a taken branch or jal this cycle
- cnt_clear  in  1  synchronous clear of both counters
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID clear to NOP
- id_ex_write  out  1  1 = load ID/EX; 0 = bubble
- stall_active  out  1  registered; 1 while in STALL
- state  out  2  current FSM state
- stall_cycles  out  CNT_W  count of load-use stall cycles
- flush_events  out  CNT_W  count of redirect cycles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=RUN, stall counter=0, stall_active=0, both performance counters=0.
  - While rst_n=0, outputs are forced: pc_write=0, if_id_write=0, id_ex_write=0, if_id_flush=1.
- Hazard term:
  - hz = ex_mem_read & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
  - rd=0 never causes a hazard.
- Enable outputs are combinational from state and inputs, so they take effect in the same cycle as the condition.
- RUN, no hz, no redirect: pc_write=1, if_id_write=1, id_ex_write=1, if_id_flush=0.
- RUN with hz and no redirect:
  - pc_write=0, if_id_write=0, id_ex_write=0 (one bubble), stall_cycles +1.
  - LOAD_LATENCY=1: stay in RUN.
  - LOAD_LATENCY>1: go to STALL with remaining count = LOAD_LATENCY-1.
- STALL:
  - Same held outputs as a RUN hazard cycle; stall_cycles +1 each cycle.
  - EX holds a bubble, so ex_mem_read and ex_rd are ignored.
  - Remaining count decrements each cycle; when it equals 1, next state is RUN.
  - Total stall length per hazard = exactly LOAD_LATENCY cycles.
- Redirect (ex_redirect=1, in any state):
  - if_id_flush=1, id_ex_write=0, pc_write=1, if_id_write=1.
  - if_id_flush dominates if_id_write; IF/ID loads NOP.
  - flush_events +1.
  - Redirect beats hz in the same cycle: no stall, no stall_cycles increment.
  - Redirect in STALL aborts the stall: next state RUN, remaining count cleared.
- stall_active is registered and equals (next state==STALL); it asserts one cycle after STALL entry is decided.
- Counters:
  - Saturate at all-ones; no wrap.
  - cnt_clear=1 sets both to 0 next edge; clear beats a simultaneous increment.
- Reset mid-STALL: returns to RUN immediately; first cycle after release is a normal RUN cycle.
- Encoding: state 2'b00=RUN, 2'b01=STALL, others unused. An unused code recovers to RUN on the next edge with all enables 1.

Decomposition:
- Shared package/header pipe_defs holds:
  - state encodings ST_RUN and ST_STALL
  - REG_X0=5'd0
  - LOAD_LATENCY default value
- One sub-module, sat_counter (CNT_W, inc, clr, async active-low reset), instantiated twice: stall_cycles and flush_events.

Test Plan:
- Basic load-use (LOAD_LATENCY=1): ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> that cycle pc_write=0, if_id_write=0, id_ex_write=0; next cycle all 1; stall_cycles=1; state stays RUN.
- No false hazards: ex_rd=0 with id_rs1=0/use=1; ex_rd=7 with id_rs2=7/id_use_rs2=0; ex_mem_read=0 with rd match -> no stall in any case, stall_cycles=0.
- Long latency (LOAD_LATENCY=3): single hz cycle -> exactly 3 consecutive stall cycles; state=STALL on cycles 2-3; stall_active high 2 cycles; stall_cycles=3; then RUN.
- Redirect: ex_redirect=1 -> if_id_flush=1, id_ex_write=0, pc_write=1, flush_events=1.
- Redirect with hazard: ex_redirect=1 with hz=1 -> no stall.
- Redirect mid-stall: LOAD_LATENCY=3, redirect on second stall cycle -> RUN next cycle, stall_cycles=2.
- Reset and counters:
  - rst_n low mid-STALL -> immediate RUN, counters 0, if_id_flush=1 while low.
  - CNT_W=4: 20 stall cycles -> stall_cycles=15 (saturated).
  - cnt_clear with simultaneous increment -> 0.
